// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared state encoding, mode constants and default watchdog depth for the AES job sequencer
package aes_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_PUSH  = 3'd1,
        TEXT_PUSH = 3'd2,
        BUSY      = 3'd3,
        RESULT    = 3'd4
    } seqState_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/aes_seq_watchdog.sv
// aes_seq_watchdog: cycle counter that flags the last permitted cycle of a core handshake wait
module aes_seq_watchdog
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count;

    // Restart on entry to a wait state, advance once per waiting cycle
    always_ff @(posedge Clk) begin
        if (Rst || clear)
            count <= '0;
        else if (enable)
            count <= count + CW'(1);
    end

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/aes_job_sequencer.sv
// aes_job_sequencer: sequences host key/text words through the AES core handshakes and returns results
module aes_job_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             HostValid,
    output logic             HostReady,
    input  logic             HostKeyLoad,
    input  logic             HostMode,
    input  logic [127:0]     HostData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [127:0]     OutData,
    output logic             CoreSel,
    output logic [127:0]     CoreText,
    output logic [127:0]     CoreKey,
    output logic             CoreKeyRy,
    input  logic             CoreKeyDone,
    output logic             CoreReadRy,
    input  logic             CoreReadEn,
    input  logic             CoreWriteRy,
    input  logic [127:0]     CoreResult,
    output logic             CoreWriteEn,
    output logic             KeyValid,
    output logic             ErrNoKey,
    output logic             ErrTimeout,
    input  logic             ErrClear,
    output logic [CNT_W-1:0] BlockCount
);

    seqState_e state, nextState;
    logic      hostFire, waitEvent, wdEnable, wdClear, wdExpired, timeoutHit;

    assign hostFire   = HostValid && HostReady;
    assign waitEvent  = (state == KEY_PUSH  && CoreKeyDone) ||
                        (state == TEXT_PUSH && CoreReadEn)  ||
                        (state == BUSY      && CoreWriteRy);
    assign wdEnable   = state inside {KEY_PUSH, TEXT_PUSH, BUSY};
    assign wdClear    = (nextState != state) && (nextState inside {KEY_PUSH, TEXT_PUSH, BUSY});
    assign timeoutHit = wdExpired && !waitEvent;

    aes_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) watchdog (
        .Clk     (Clk),
        .Rst     (Rst),
        .clear   (wdClear),
        .enable  (wdEnable),
        .expired (wdExpired)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    // Next state: each wait ends on its awaited core event or on watchdog expiry
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:      nextState = !hostFire ? IDLE : HostKeyLoad ? KEY_PUSH : KeyValid ? TEXT_PUSH : IDLE;
            KEY_PUSH:  nextState = (CoreKeyDone || timeoutHit) ? IDLE : KEY_PUSH;
            TEXT_PUSH: nextState = CoreReadEn ? BUSY : timeoutHit ? IDLE : TEXT_PUSH;
            BUSY:      nextState = CoreWriteRy ? RESULT : timeoutHit ? IDLE : BUSY;
            RESULT:    nextState = OutReady ? IDLE : RESULT;
            default:   nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; reset drops them in the same cycle
    always_comb begin
        HostReady   = !Rst && state == IDLE;
        CoreKeyRy   = !Rst && state == KEY_PUSH;
        CoreReadRy  = !Rst && state == TEXT_PUSH;
        OutValid    = !Rst && state == RESULT;
        CoreWriteEn = !Rst && state == BUSY && CoreWriteRy;
    end

    // Datapath registers, key validity, sticky errors and block counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            CoreKey    <= '0;
            CoreText   <= '0;
            CoreSel    <= MODE_ENC;
            OutData    <= '0;
            KeyValid   <= 1'b0;
            ErrNoKey   <= 1'b0;
            ErrTimeout <= 1'b0;
            BlockCount <= '0;
        end else begin
            if (ErrClear) begin
                ErrNoKey   <= 1'b0;
                ErrTimeout <= 1'b0;
            end
            if (state == IDLE && hostFire) begin
                if (HostKeyLoad) begin
                    CoreKey  <= HostData;
                    KeyValid <= 1'b0;
                end else if (KeyValid) begin
                    CoreText <= HostData;
                    CoreSel  <= (HostMode == MODE_DEC);
                end else begin
                    ErrNoKey <= 1'b1;
                end
            end
            if (state == KEY_PUSH && CoreKeyDone)
                KeyValid <= 1'b1;
            if (timeoutHit) begin
                KeyValid   <= 1'b0;
                ErrTimeout <= 1'b1;
            end
            if (state == BUSY && CoreWriteRy)
                OutData <= CoreResult;
            if (state == RESULT && OutReady)
                BlockCount <= BlockCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// tb_aes_job_sequencer: randomized job traffic against a transaction-level model of the sequencer
module tb_aes_job_sequencer;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          HostValid = 1'b0, HostKeyLoad = 1'b0, HostMode = 1'b0;
    logic [127:0]  HostData = '0;
    logic          HostReady, OutValid, CoreSel, CoreKeyRy, CoreReadRy, CoreWriteEn;
    logic          KeyValid, ErrNoKey, ErrTimeout;
    logic          OutReady = 1'b0, CoreKeyDone = 1'b0, CoreReadEn = 1'b0, CoreWriteRy = 1'b0, ErrClear = 1'b0;
    logic [127:0]  CoreResult = '0;
    logic [127:0]  OutData, CoreText, CoreKey;
    logic [CW-1:0] BlockCount;

    bit mKeyValid, mErrNoKey, mErrTimeout;
    int mBlocks;
    int assertCount = 0;
    int failCount = 0;

    always #5 Clk = ~Clk;

    aes_job_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .Clk(Clk), .Rst(Rst),
        .HostValid(HostValid), .HostReady(HostReady), .HostKeyLoad(HostKeyLoad), .HostMode(HostMode), .HostData(HostData),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
        .CoreSel(CoreSel), .CoreText(CoreText), .CoreKey(CoreKey),
        .CoreKeyRy(CoreKeyRy), .CoreKeyDone(CoreKeyDone), .CoreReadRy(CoreReadRy), .CoreReadEn(CoreReadEn),
        .CoreWriteRy(CoreWriteRy), .CoreResult(CoreResult), .CoreWriteEn(CoreWriteEn),
        .KeyValid(KeyValid), .ErrNoKey(ErrNoKey), .ErrTimeout(ErrTimeout), .ErrClear(ErrClear),
        .BlockCount(BlockCount)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic sample();
        @(negedge Clk);
    endtask

    task automatic checkIdle();
        sample();
        checkEq("idleHostReady", HostReady, 1'b1);
        checkEq("idleKeyValid", KeyValid, mKeyValid);
        checkEq("idleErrNoKey", ErrNoKey, mErrNoKey);
        checkEq("idleErrTimeout", ErrTimeout, mErrTimeout);
        checkEq("idleBlockCount", BlockCount, mBlocks);
        checkEq("idleOutValid", OutValid, 1'b0);
        checkEq("idleKeyRy", CoreKeyRy, 1'b0);
        checkEq("idleReadRy", CoreReadRy, 1'b0);
        tick();
    endtask

    task automatic idleJunk(input int n);
        for (int i = 0; i < n; i++) begin
            CoreKeyDone = 1'($urandom_range(0, 1));
            CoreReadEn  = 1'($urandom_range(0, 1));
            CoreWriteRy = 1'($urandom_range(0, 1));
            CoreResult  = rand128();
            sample();
            checkEq("junkHostReady", HostReady, 1'b1);
            checkEq("junkWriteEn", CoreWriteEn, 1'b0);
            checkEq("junkKeyValid", KeyValid, mKeyValid);
            tick();
        end
        CoreKeyDone = 1'b0;
        CoreReadEn  = 1'b0;
        CoreWriteRy = 1'b0;
    endtask

    task automatic hostWord(input bit keyLoad, input bit mode, input logic [127:0] data, input bit clr);
        HostValid   = 1'b1;
        HostKeyLoad = keyLoad;
        HostMode    = mode;
        HostData    = data;
        ErrClear    = clr;
        sample();
        checkEq("acceptHostReady", HostReady, 1'b1);
        tick();
        HostValid = 1'b0;
        ErrClear  = 1'b0;
        HostData  = rand128();
        if (clr) begin
            mErrNoKey   = 1'b0;
            mErrTimeout = 1'b0;
        end
    endtask

    // d = cycle of KEY_PUSH in which the core acknowledges (beyond TO means never)
    task automatic runKey(input logic [127:0] k, input int d, input bit clr);
        hostWord(1'b1, 1'b0, k, clr);
        mKeyValid = 1'b0;
        for (int c = 1; c <= (d < TO ? d : TO); c++) begin
            CoreKeyDone = (c == d);
            sample();
            checkEq("keyRy", CoreKeyRy, 1'b1);
            checkEq("keyPushHostReady", HostReady, 1'b0);
            checkEq("coreKey", CoreKey, k);
            tick();
            CoreKeyDone = 1'b0;
        end
        if (d <= TO)
            mKeyValid = 1'b1;
        else begin
            mKeyValid   = 1'b0;
            mErrTimeout = 1'b1;
        end
        checkIdle();
    endtask

    // dr/dw = cycle of TEXT_PUSH/BUSY with the core event, od = cycles OutReady stays low
    task automatic runText(input logic [127:0] t, input bit mode, input int dr, input int dw,
                           input logic [127:0] res, input int od, input bit clr);
        hostWord(1'b0, mode, t, clr);
        if (!mKeyValid) begin
            mErrNoKey = 1'b1;
            sample();
            checkEq("noKeyReadRy", CoreReadRy, 1'b0);
            checkEq("noKeyErr", ErrNoKey, 1'b1);
            tick();
        end else begin
            for (int c = 1; c <= (dr < TO ? dr : TO); c++) begin
                CoreReadEn = (c == dr);
                sample();
                checkEq("readRy", CoreReadRy, 1'b1);
                checkEq("coreSel", CoreSel, mode);
                checkEq("coreText", CoreText, t);
                tick();
                CoreReadEn = 1'b0;
            end
            if (dr > TO) begin
                mKeyValid   = 1'b0;
                mErrTimeout = 1'b1;
            end else begin
                for (int c = 1; c <= (dw < TO ? dw : TO); c++) begin
                    CoreWriteRy = (c == dw);
                    CoreResult  = (c == dw) ? res : rand128();
                    sample();
                    checkEq("writeEn", CoreWriteEn, (c == dw));
                    checkEq("busyOutValid", OutValid, 1'b0);
                    checkEq("busyReadRy", CoreReadRy, 1'b0);
                    tick();
                    CoreWriteRy = 1'b0;
                end
                if (dw > TO) begin
                    mKeyValid   = 1'b0;
                    mErrTimeout = 1'b1;
                end else begin
                    for (int i = 0; i < od; i++) begin
                        CoreKeyDone = 1'($urandom_range(0, 1));
                        CoreReadEn  = 1'($urandom_range(0, 1));
                        CoreWriteRy = 1'($urandom_range(0, 1));
                        CoreResult  = rand128();
                        sample();
                        checkEq("holdOutValid", OutValid, 1'b1);
                        checkEq("holdOutData", OutData, res);
                        checkEq("holdHostReady", HostReady, 1'b0);
                        checkEq("holdWriteEn", CoreWriteEn, 1'b0);
                        checkEq("holdErrTimeout", ErrTimeout, mErrTimeout);
                        tick();
                        CoreKeyDone = 1'b0;
                        CoreReadEn  = 1'b0;
                        CoreWriteRy = 1'b0;
                    end
                    OutReady = 1'b1;
                    sample();
                    checkEq("outValid", OutValid, 1'b1);
                    checkEq("outData", OutData, res);
                    tick();
                    OutReady = 1'b0;
                    mBlocks  = (mBlocks + 1) % (1 << CW);
                end
            end
        end
        checkIdle();
    endtask

    initial begin
        logic [127:0] k;
        mKeyValid   = 1'b0;
        mErrNoKey   = 1'b0;
        mErrTimeout = 1'b0;
        mBlocks     = 0;
        tick();
        tick();
        sample();
        checkEq("rstHostReady", HostReady, 1'b0);
        checkEq("rstCoreKey", CoreKey, '0);
        checkEq("rstOutData", OutData, '0);
        checkEq("rstBlockCount", BlockCount, '0);
        tick();
        Rst = 1'b0;
        checkIdle();

        runText(rand128(), 1'b0, 1, 1, rand128(), 0, 1'b0);
        runText(rand128(), 1'b0, 1, 1, rand128(), 0, 1'b1);
        runKey(128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 1'b1);
        runText(128'h3243f6a8885a308d313198a2e0370734, 1'b0, 2, 5, 128'h3925841d02dc09fbdc118597196a0b32, 1, 1'b0);
        runText(rand128(), 1'b1, 1, 99, rand128(), 0, 1'b0);
        idleJunk(3);
        runKey(rand128(), 1, 1'b1);
        runText(rand128(), 1'b1, 3, 16, rand128(), 0, 1'b0);
        runText(rand128(), 1'b0, 16, 2, rand128(), 50, 1'b0);
        for (int i = 0; i < 17; i++)
            runText(rand128(), 1'($urandom_range(0, 1)), 1, 1, rand128(), 0, 1'b0);
        runKey(rand128(), 17, 1'b0);
        idleJunk(2);
        runKey(rand128(), 16, 1'b1);

        for (int j = 0; j < 40; j++) begin
            bit clr;
            clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                runKey(rand128(), $urandom_range(1, 18), clr);
            else
                runText(rand128(), 1'($urandom_range(0, 1)), $urandom_range(1, 18), $urandom_range(1, 18),
                        rand128(), $urandom_range(0, 4), clr);
            idleJunk($urandom_range(0, 2));
        end

        k = rand128();
        runKey(k, 3, 1'b0);
        hostWord(1'b0, 1'b1, rand128(), 1'b0);
        Rst = 1'b1;
        sample();
        checkEq("rstDropReadRy", CoreReadRy, 1'b0);
        tick();
        sample();
        checkEq("rstMidHostReady", HostReady, 1'b0);
        checkEq("rstMidReadRy", CoreReadRy, 1'b0);
        checkEq("rstMidCoreSel", CoreSel, 1'b0);
        checkEq("rstMidCoreText", CoreText, '0);
        checkEq("rstMidCoreKey", CoreKey, '0);
        checkEq("rstMidOutData", OutData, '0);
        checkEq("rstMidKeyValid", KeyValid, 1'b0);
        checkEq("rstMidErrs", {ErrNoKey, ErrTimeout}, 2'b00);
        checkEq("rstMidBlockCount", BlockCount, '0);
        checkEq("rstMidOutValid", OutValid, 1'b0);
        tick();
        Rst         = 1'b0;
        mKeyValid   = 1'b0;
        mErrNoKey   = 1'b0;
        mErrTimeout = 1'b0;
        mBlocks     = 0;
        checkIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/aes_job_sequencer.md
Name: aes_job_sequencer

Overview:
- Controller between the serial front end and the AES128 core.
- Accepts key and text words from the host side and runs the core's key-load, text-load and result handshakes in order.
- Delivers results with valid/ready and guards every core wait with a watchdog.
- Provides sticky error flags and a processed-block counter.

Parameters:
- TIMEOUT_CYCLES, 4096: maximum cycles spent waiting on any core handshake before abort.
- CNT_W, 16: width of the block counter.

Ports:
- Clk  input  1  system clock; all logic on rising edge
- Rst  input  1  synchronous, active-high reset
- HostValid  input  1  host word valid
- HostReady  output  1  sequencer can accept a host word
- HostKeyLoad  input  1  1 = HostData is a key, 0 = HostData is text
- HostMode  input  1  0 = encrypt, 1 = decrypt (text words only)
- HostData  input  128  key or text word
- OutValid  output  1  result word valid
- OutReady  input  1  consumer accepts result
- OutData  output  128  result word
- CoreSel  output  1  ProgramSelector to core: latched mode
- CoreText  output  128  text register to core
- CoreKey  output  128  key register to core
- CoreKeyRy  output  1  key-load request, level
- CoreKeyDone  input  1  core finished key expansion, pulse
- CoreReadRy  output  1  text-load request, level
- CoreReadEn  input  1  core took text, pulse
- CoreWriteRy  input  1  core result valid, level
- CoreResult  input  128  core result
- CoreWriteEn  output  1  result consumed, 1-cycle pulse
- KeyValid  output  1  a key has been loaded successfully
- ErrNoKey  output  1  sticky: text arrived with no valid key
- ErrTimeout  output  1  sticky: watchdog expired
- ErrClear  input  1  clears both sticky errors
- BlockCount  output  CNT_W  results delivered, wraps modulo 2^CNT_W

Behaviour:
- Reset values:
  - All outputs 0, including registers OutData, CoreText, CoreKey, BlockCount and CoreSel.
  - State returns to IDLE.
  - Reset mid-operation drops requests to the core immediately, with no completion pulse.
- States: IDLE, KEY_PUSH, TEXT_PUSH, BUSY, RESULT.
- IDLE:
  - HostReady=1.
  - Handshake occurs on HostValid&HostReady.
  - Key word: latch into CoreKey, clear KeyValid, go to KEY_PUSH.
  - Text word with KeyValid=1: latch CoreText and CoreSel<=HostMode, go to TEXT_PUSH.
  - Text word with KeyValid=0: word is accepted and discarded, ErrNoKey<=1, stay in IDLE.
- KEY_PUSH:
  - CoreKeyRy=1.
  - On CoreKeyDone: KeyValid<=1, go to IDLE.
- TEXT_PUSH:
  - CoreReadRy=1.
  - On CoreReadEn, go to BUSY.
- BUSY:
  - On CoreWriteRy: OutData<=CoreResult and CoreWriteEn=1 for exactly that cycle, go to RESULT.
- RESULT:
  - OutValid=1 and OutData held stable.
  - On OutReady: BlockCount increments with wrap, go to IDLE.
  - No new host word is accepted until the next IDLE cycle.
- HostReady=0 in every state except IDLE.
- Latency:
  - Host accept in cycle N gives CoreReadRy/CoreKeyRy high in cycle N+1.
  - CoreWriteRy sampled in cycle M gives OutValid high in cycle M+1.
  - Minimum round trip is 4 cycles plus core time.
- Watchdog:
  - Counter clears on entry to KEY_PUSH, TEXT_PUSH or BUSY and counts each cycle in those states.
  - When count==TIMEOUT_CYCLES-1 and the awaited event is absent: ErrTimeout<=1, KeyValid<=0, all core requests deasserted, go to IDLE.
  - If the awaited event arrives in the expiry cycle, the event wins and no error is raised.
  - The counter is idle in IDLE and RESULT; RESULT waits on OutReady indefinitely.
- Error flags:
  - ErrClear clears both errors.
  - If an error sets in the same cycle as ErrClear, the set wins.
  - Errors do not block operation, except that a timeout clears KeyValid.
- Unsolicited core pulses are ignored: CoreKeyDone outside KEY_PUSH, CoreReadEn outside TEXT_PUSH, CoreWriteRy outside BUSY.
- A new key word always invalidates the old key until CoreKeyDone.

Decomposition:
- Package aes_seq_pkg holds:
  - the state enum;
  - MODE_ENC=0 and MODE_DEC=1;
  - default TIMEOUT_CYCLES.
- Sub-module aes_seq_watchdog:
  - inputs: clear, enable;
  - output: expired;
  - $clog2(TIMEOUT_CYCLES)-bit counter.

Test Plan:
- Key 2b7e151628aed2a6abf7158809cf4f3c with the core model acking after 10 cycles -> CoreKeyRy high cycles 1-10, KeyValid=1, HostReady back in IDLE.
- Text 3243f6a8885a308d313198a2e0370734, HostMode=0, model returns 3925841d02dc09fbdc118597196a0b32 -> CoreSel=0, one CoreWriteEn pulse, OutData matches, BlockCount=1.
- Text before any key -> word accepted, ErrNoKey=1, no CoreReadRy. ErrClear together with a second keyless text -> ErrNoKey stays 1.
- Core never asserts CoreWriteRy, TIMEOUT_CYCLES=16 -> ErrTimeout at cycle 16 of BUSY, KeyValid=0, state IDLE. Repeat with CoreWriteRy exactly on cycle 16 -> no error, result delivered.
- OutReady held low for 50 cycles -> OutValid and OutData stable, HostReady=0, no watchdog error. Then OutReady=1 -> IDLE next cycle.
- CNT_W=4, 17 blocks -> BlockCount wraps to 1. Rst asserted during TEXT_PUSH -> all outputs 0 the next cycle.
